// File: rtl/bus_channel_monitor_pkg.sv
// ---------------------------------------------------------------------------
// bus_channel_monitor_pkg : shared error-bit indices and lane state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bus_channel_monitor_pkg;

  localparam int ERR_RESET   = 0;
  localparam int ERR_DROP    = 1;
  localparam int ERR_DATA    = 2;
  localparam int ERR_TIMEOUT = 3;
  localparam int ERR_WIDTH   = 4;

  typedef enum logic [0:0] {
    LANE_IDLE  = 1'b0,
    LANE_STALL = 1'b1
  } lane_state_e;

endpackage

`default_nettype wire

// File: rtl/bus_channel_monitor_lane.sv
// ---------------------------------------------------------------------------
// bus_channel_monitor_lane : one valid/ready channel checker and counter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_channel_monitor_lane
  import bus_channel_monitor_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 64,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   armed_i,
  input  logic                   valid_i,
  input  logic                   ready_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic [ERR_WIDTH-1:0]   err_o,
  output logic [COUNT_WIDTH-1:0] count_o
);

  // Counter max exceeds TIMEOUT so saturation cannot produce a second match.
  localparam int STALL_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 2);
  localparam logic [STALL_W-1:0] TO_VAL = STALL_W'(TIMEOUT);

  lane_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [STALL_W-1:0]      stall_q, stall_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    w_stalling;
  logic [COUNT_WIDTH-1:0]  w_count_inc;

  assign w_count_inc = (count_q == '1) ? count_q : count_q + COUNT_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stall_d    = stall_q;
    count_d    = count_q;
    w_stalling = 1'b0;
    err_o      = '0;
    err_o[ERR_RESET] = armed_i & valid_i;
    unique case (state_q)
      LANE_IDLE: begin
        if (valid_i) begin
          if (ready_i) begin
            count_d = w_count_inc;
          end else begin
            hold_d     = data_i;
            stall_d    = STALL_W'(1);
            state_d    = LANE_STALL;
            w_stalling = 1'b1;
          end
        end
      end
      LANE_STALL: begin
        if (!valid_i) begin
          err_o[ERR_DROP] = 1'b1;
          stall_d         = '0;
          state_d         = LANE_IDLE;
        end else begin
          err_o[ERR_DATA] = (data_i != hold_q);
          if (ready_i) begin
            count_d = w_count_inc;
            stall_d = '0;
            state_d = LANE_IDLE;
          end else begin
            stall_d    = (stall_q == '1) ? stall_q : stall_q + STALL_W'(1);
            w_stalling = 1'b1;
          end
        end
      end
      default: state_d = LANE_IDLE;
    endcase
    if ((TIMEOUT > 0) && w_stalling && (stall_d == TO_VAL)) begin
      err_o[ERR_TIMEOUT] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LANE_IDLE;
      hold_q  <= '0;
      stall_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stall_q <= stall_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/bus_channel_monitor.sv
// ---------------------------------------------------------------------------
// bus_channel_monitor : multi-channel valid/ready monitor, sticky errors,
// fire pulse and first-error capture. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_channel_monitor
  import bus_channel_monitor_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 64,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [CHANNELS-1:0]             valid,
  input  logic [CHANNELS-1:0]             ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]  data,
  input  logic                            clear,
  output logic [CHANNELS*ERR_WIDTH-1:0]   err_flags,
  output logic                            fire,
  output logic                            first_err_valid,
  output logic [3:0]                      first_err_chan,
  output logic [3:0]                      first_err_code,
  output logic [CHANNELS*COUNT_WIDTH-1:0] tran_count
);

  logic                          armed_q;
  logic [CHANNELS*ERR_WIDTH-1:0] w_ev;
  logic [CHANNELS*ERR_WIDTH-1:0] flags_q, flags_d;
  logic                          fire_q, fire_d;
  logic                          fv_q, fv_d;
  logic [3:0]                    fchan_q, fchan_d;
  logic [ERR_WIDTH-1:0]          fcode_q, fcode_d;
  logic                          w_any;
  logic [3:0]                    w_chan;
  logic [ERR_WIDTH-1:0]          w_code;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    bus_channel_monitor_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .TIMEOUT     (TIMEOUT),
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .armed_i (armed_q),
      .valid_i (valid[g]),
      .ready_i (ready[g]),
      .data_i  (data[g*DATA_WIDTH +: DATA_WIDTH]),
      .err_o   (w_ev[g*ERR_WIDTH +: ERR_WIDTH]),
      .count_o (tran_count[g*COUNT_WIDTH +: COUNT_WIDTH])
    );
  end

  always_comb begin
    w_any  = |w_ev;
    w_chan = '0;
    w_code = '0;
    // Descending scan so the lowest erroring channel is the one left standing.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (|w_ev[i*ERR_WIDTH +: ERR_WIDTH]) begin
        w_chan = 4'(i);
        w_code = w_ev[i*ERR_WIDTH +: ERR_WIDTH];
      end
    end

    flags_d = clear ? w_ev : (flags_q | w_ev);
    fire_d  = w_any;
    fv_d    = fv_q;
    fchan_d = fchan_q;
    fcode_d = fcode_q;
    if (clear) begin
      fv_d    = 1'b0;
      fchan_d = '0;
      fcode_d = '0;
    end
    if ((clear || !fv_q) && w_any) begin
      fv_d    = 1'b1;
      fchan_d = w_chan;
      fcode_d = w_code;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b1;
      flags_q <= '0;
      fire_q  <= 1'b0;
      fv_q    <= 1'b0;
      fchan_q <= '0;
      fcode_q <= '0;
    end else begin
      armed_q <= 1'b0;
      flags_q <= flags_d;
      fire_q  <= fire_d;
      fv_q    <= fv_d;
      fchan_q <= fchan_d;
      fcode_q <= fcode_d;
    end
  end

  assign err_flags       = flags_q;
  assign fire            = fire_q;
  assign first_err_valid = fv_q;
  assign first_err_chan  = fchan_q;
  assign first_err_code  = fcode_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_channel_monitor.sv
// ---------------------------------------------------------------------------
// tb_bus_channel_monitor : directed vector bench for bus_channel_monitor
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bus_channel_monitor;

  localparam logic [31:0] A = 32'hDEADBEEF;
  localparam logic [31:0] B = 32'h12345678;
  localparam int NVEC = 39;

  typedef struct packed {
    logic [1:0]  v;
    logic [1:0]  r;
    logic [31:0] d0;
    logic        clr;
    logic [7:0]  flags;
    logic        fire;
    logic [15:0] c0;
    logic [15:0] c1;
    logic        fv;
    logic [3:0]  fch;
    logic [3:0]  fcode;
    logic [7:0]  sflags;
    logic [1:0]  sc0;
    logic [1:0]  sc1;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [1:0]  valid;
  logic [1:0]  ready;
  logic [63:0] data;
  logic        clear;

  logic [7:0]  err_flags;
  logic        fire;
  logic        first_err_valid;
  logic [3:0]  first_err_chan;
  logic [3:0]  first_err_code;
  logic [31:0] tran_count;

  logic [7:0]  s_err_flags;
  logic        s_fire;
  logic        s_first_err_valid;
  logic [3:0]  s_first_err_chan;
  logic [3:0]  s_first_err_code;
  logic [3:0]  s_tran_count;

  int checks = 0;
  int errors = 0;
  vec_t tbl [0:NVEC-1];

  bus_channel_monitor #(
    .CHANNELS(2), .DATA_WIDTH(32), .TIMEOUT(4), .COUNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset), .valid(valid), .ready(ready), .data(data),
    .clear(clear), .err_flags(err_flags), .fire(fire),
    .first_err_valid(first_err_valid), .first_err_chan(first_err_chan),
    .first_err_code(first_err_code), .tran_count(tran_count)
  );

  // Same stimulus; timeout check disabled and 2-bit counters to show saturation.
  bus_channel_monitor #(
    .CHANNELS(2), .DATA_WIDTH(32), .TIMEOUT(0), .COUNT_WIDTH(2)
  ) dut_sat (
    .clock(clock), .reset(reset), .valid(valid), .ready(ready), .data(data),
    .clear(clear), .err_flags(s_err_flags), .fire(s_fire),
    .first_err_valid(s_first_err_valid), .first_err_chan(s_first_err_chan),
    .first_err_code(s_first_err_code), .tran_count(s_tran_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input int v, input int r, input logic [31:0] d0, input int clr,
                              input int fl, input int fi, input int c0, input int c1,
                              input int fv, input int fch, input int fcode,
                              input int sfl, input int sc0, input int sc1);
    vec_t t;
    t.v = 2'(v);   t.r = 2'(r);   t.d0 = d0;   t.clr = 1'(clr);
    t.flags = 8'(fl); t.fire = 1'(fi); t.c0 = 16'(c0); t.c1 = 16'(c1);
    t.fv = 1'(fv); t.fch = 4'(fch); t.fcode = 4'(fcode);
    t.sflags = 8'(sfl); t.sc0 = 2'(sc0); t.sc1 = 2'(sc1);
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset release with ch0 handshaking, then clear.
    tbl[0]  = mk(1, 1, A, 0, 'h01, 1, 1, 0, 1, 0, 1, 'h01, 1, 0);
    tbl[1]  = mk(0, 0, A, 0, 'h01, 0, 1, 0, 1, 0, 1, 'h01, 1, 0);
    tbl[2]  = mk(0, 0, A, 1, 'h00, 0, 1, 0, 0, 0, 0, 'h00, 1, 0);
    for (int i = 3; i < 8; i++)
      tbl[i] = mk(2, 2, A, 0, 'h00, 0, 1, i - 2, 0, 0, 0, 'h00, 1, (i - 2 > 3) ? 3 : i - 2);
    // ch0 stall with a payload glitch, then handshake.
    tbl[8]  = mk(1, 0, A,     0, 'h00, 0, 1, 5, 0, 0, 0, 'h00, 1, 3);
    tbl[9]  = mk(1, 0, 32'h0, 0, 'h04, 1, 1, 5, 1, 0, 4, 'h04, 1, 3);
    tbl[10] = mk(1, 0, A,     0, 'h04, 0, 1, 5, 1, 0, 4, 'h04, 1, 3);
    tbl[11] = mk(1, 1, A,     0, 'h04, 0, 2, 5, 1, 0, 4, 'h04, 2, 3);
    tbl[12] = mk(0, 0, A,     1, 'h00, 0, 2, 5, 0, 0, 0, 'h00, 2, 3);
    // ch1 valid dropped during a stall.
    tbl[13] = mk(2, 0, A, 0, 'h00, 0, 2, 5, 0, 0, 0, 'h00, 2, 3);
    tbl[14] = mk(2, 0, A, 0, 'h00, 0, 2, 5, 0, 0, 0, 'h00, 2, 3);
    tbl[15] = mk(0, 0, A, 0, 'h20, 1, 2, 5, 1, 1, 2, 'h20, 2, 3);
    tbl[16] = mk(0, 0, A, 1, 'h00, 0, 2, 5, 0, 0, 0, 'h00, 2, 3);
    // ch0 ten-cycle stall, timeout at stall cycle 4, clear mid-stall.
    for (int i = 17; i < 20; i++)
      tbl[i] = mk(1, 0, A, 0, 'h00, 0, 2, 5, 0, 0, 0, 'h00, 2, 3);
    tbl[20] = mk(1, 0, A, 0, 'h08, 1, 2, 5, 1, 0, 8, 'h00, 2, 3);
    tbl[21] = mk(1, 0, A, 0, 'h08, 0, 2, 5, 1, 0, 8, 'h00, 2, 3);
    tbl[22] = mk(1, 0, A, 1, 'h00, 0, 2, 5, 0, 0, 0, 'h00, 2, 3);
    for (int i = 23; i < 27; i++)
      tbl[i] = mk(1, 0, A, 0, 'h00, 0, 2, 5, 0, 0, 0, 'h00, 2, 3);
    tbl[27] = mk(1, 1, A, 0, 'h00, 0, 3, 5, 0, 0, 0, 'h00, 3, 3);
    // Simultaneous drops; then clear racing a new ch1 error.
    tbl[28] = mk(3, 0, A, 0, 'h00, 0, 3, 5, 0, 0, 0, 'h00, 3, 3);
    tbl[29] = mk(0, 0, A, 0, 'h22, 1, 3, 5, 1, 0, 2, 'h22, 3, 3);
    tbl[30] = mk(3, 0, A, 0, 'h22, 0, 3, 5, 1, 0, 2, 'h22, 3, 3);
    tbl[31] = mk(1, 0, A, 1, 'h20, 1, 3, 5, 1, 1, 2, 'h20, 3, 3);
    tbl[32] = mk(1, 1, A, 0, 'h20, 0, 4, 5, 1, 1, 2, 'h20, 3, 3);
    // DATA and TIMEOUT together, then a later DROP that must not recapture.
    tbl[33] = mk(0, 0, A, 1, 'h00, 0, 4, 5, 0, 0, 0, 'h00, 3, 3);
    for (int i = 34; i < 37; i++)
      tbl[i] = mk(1, 0, A, 0, 'h00, 0, 4, 5, 0, 0, 0, 'h00, 3, 3);
    tbl[37] = mk(1, 0, 32'h0, 0, 'h0C, 1, 4, 5, 1, 0, 'hC, 'h04, 3, 3);
    tbl[38] = mk(0, 0, A,     0, 'h0E, 1, 4, 5, 1, 0, 'hC, 'h06, 3, 3);

    reset = 1'b1;
    valid = tbl[0].v;
    ready = tbl[0].r;
    data  = {B, tbl[0].d0};
    clear = 1'b0;
    #12;
    chk("rst_flags", -1, err_flags, 0);
    chk("rst_fire",  -1, fire, 0);
    chk("rst_fv",    -1, first_err_valid, 0);
    chk("rst_fch",   -1, first_err_chan, 0);
    chk("rst_fcode", -1, first_err_code, 0);
    chk("rst_count", -1, tran_count, 0);
    chk("rst_scount", -1, s_tran_count, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      valid = tbl[i].v;
      ready = tbl[i].r;
      data  = {B, tbl[i].d0};
      clear = tbl[i].clr;
      tick();
      chk("flags",  i, err_flags, tbl[i].flags);
      chk("fire",   i, fire, tbl[i].fire);
      chk("count0", i, tran_count[15:0], tbl[i].c0);
      chk("count1", i, tran_count[31:16], tbl[i].c1);
      chk("fvalid", i, first_err_valid, tbl[i].fv);
      chk("fchan",  i, first_err_chan, tbl[i].fch);
      chk("fcode",  i, first_err_code, tbl[i].fcode);
      chk("sflags", i, s_err_flags, tbl[i].sflags);
      chk("scount0", i, s_tran_count[1:0], tbl[i].sc0);
      chk("scount1", i, s_tran_count[3:2], tbl[i].sc1);
    end

    // Reset asserted mid-stall must drop the lane back to IDLE silently.
    clear = 1'b0;
    valid = 2'b01;
    ready = 2'b00;
    data  = {B, A};
    tick();
    #3;
    reset = 1'b1;
    #1;
    chk("async_flags", 100, err_flags, 0);
    chk("async_count", 100, tran_count, 0);
    chk("async_fv",    100, first_err_valid, 0);
    valid = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_flags", 101, err_flags, 0);
    chk("post_rst_fire",  101, fire, 0);
    valid = 2'b01;
    tick();
    chk("disarmed_flags", 102, err_flags, 0);
    ready = 2'b01;
    tick();
    chk("post_rst_count0", 103, tran_count[15:0], 1);
    chk("post_rst_flags2", 103, err_flags, 0);

    // Re-arm on a second reset, with channel 1 already valid.
    #3;
    reset = 1'b1;
    valid = 2'b10;
    ready = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    chk("rearm_flags", 104, err_flags, 8'h10);
    chk("rearm_fire",  104, fire, 1);
    chk("rearm_fchan", 104, first_err_chan, 1);
    chk("rearm_fcode", 104, first_err_code, 4'b0001);
    valid = 2'b10;
    tick();
    chk("rearm_once", 105, err_flags, 8'h10);
    chk("rearm_fire_off", 105, fire, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
